mult_seq_led_board: RTL and testbench

Sequential 16x16 unsigned shift-add multiplier. It is the inverse operation of the team's sequential restoring divider, and the two can chain (quotient*divisor check) on the LED board. It has a start/done handshake and one result per WIDTH+2 cycles. It drives the board's four-digit multiplexed 7-segment display with either half of the 32-bit product, in hex.

---
 rtl/mult_seq_led_board.sv | 152 +++++++++++++++
 tb/tb_mult_seq_led_board.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mult_seq_led_board.sv
// Sequential 16x16 unsigned shift-add multiplier with start/done handshake,
// driving a four-digit multiplexed 7-segment display with half of the product.
module mult_seq_led_board #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 disp_hi,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 led1,
  output logic                 led2,
  output logic                 led3,
  output logic                 led4,
  output logic [6:0]           out
);

  localparam int unsigned CountW = $clog2(WIDTH + 1);
  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t              state;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic [CountW-1:0]   count;

  logic [WIDTH:0]      upper;
  logic [3*WIDTH-1:0]  shifted;

  // Carry out of the upper add becomes the accumulator MSB after the shift.
  always_comb begin
    upper = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) begin
      upper = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    shifted = {upper, acc[WIDTH-1:0], mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= CountW'(WIDTH);
            busy   <= 1'b1;
            state  <= StRun;
          end
        end
        StRun: begin
          if (count != '0) begin
            acc    <= shifted[3*WIDTH-1:WIDTH];
            mplier <= shifted[WIDTH-1:0];
            count  <= count - CountW'(1);
            if (count == CountW'(1)) begin
              state <= StDone;
            end
          end
        end
        StDone: begin
          product <= acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [ScanW-1:0]  scan_cnt;
  logic [1:0]        digit_sel;
  logic [WIDTH-1:0]  half;
  logic [3:0]        nib;
  logic [3:0]        led;

  always_comb begin
    half = disp_hi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
    case (digit_sel)
      2'd0:    nib = half[3:0];
      2'd1:    nib = half[7:4];
      2'd2:    nib = half[11:8];
      default: nib = half[15:12];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_sel <= 2'd0;
      led       <= 4'b0001;
      out       <= 7'b1000000;
    end else begin
      if (scan_cnt == ScanW'(SCAN_DIV - 1)) begin
        scan_cnt  <= '0;
        digit_sel <= digit_sel + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + ScanW'(1);
      end
      led <= 4'b0001 << digit_sel;
      out <= seg7(nib);
    end
  end

  assign led1 = led[0];
  assign led2 = led[1];
  assign led3 = led[2];
  assign led4 = led[3];

endmodule

// File: tb/tb_mult_seq_led_board.sv
// Directed bench for mult_seq_led_board: vector table of products plus
// hand-written sequences for handshake, reset abort and display scanning.
module tb_mult_seq_led_board;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        disp_hi = 1'b0;
  logic        busy, done;
  logic [31:0] product;
  logic        led1, led2, led3, led4;
  logic [6:0]  out;
  logic [3:0]  leds;

  int compared = 0;
  int mismatched = 0;

  mult_seq_led_board #(.WIDTH(16), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .disp_hi(disp_hi),
    .busy(busy), .done(done), .product(product),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4), .out(out)
  );

  always #5 clk = ~clk;
  assign leds = {led4, led3, led2, led1};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation and checks latency, pulse width and held product.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic [31:0] exp);
    int n;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 17);
    check("product", product, exp);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("product_held", product, exp);
  endtask

  // Waits for the led1 slot to begin, then follows the full rotation.
  task automatic show(input logic dh, input logic [27:0] segs);
    int n;
    logic [3:0] prev;
    disp_hi = dh;
    n = 0;
    while (leds == 4'b0001 && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (leds != 4'b0001 && n < 20) begin @(negedge clk); n++; end
    check("scan_led1_found", 32'(leds), 32'h1);
    check("seg_digit0", 32'(out), 32'(segs[6:0]));
    for (int i = 1; i <= 4; i++) begin
      prev = leds;
      n = 0;
      do begin @(negedge clk); n++; end while (leds == prev && n < 20);
      check("slot_len", n, 4);
      check("led_onehot", 32'(leds), 32'(4'b0001 << (i % 4)));
      check("seg_digit", 32'(out), 32'(segs[7*(i%4) +: 7]));
    end
  endtask

  initial begin
    int n, dones, t0;
    vecs[0] = '{16'd37, 16'd870, 32'h00007DBE};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[4] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[6] = '{16'h8000, 16'h0002, 32'h00010000};

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_leds", 32'(leds), 32'h1);
    check("rst_out", 32'(out), 32'b1000000);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp);

    // FFFE0001 upper half on display: E F F F
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    show(1'b1, {7'b0001110, 7'b0001110, 7'b0001110, 7'b0000110});

    // Start re-raised and operands changed mid-run must be ignored.
    @(negedge clk);
    a = 16'd3; b = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin start = 1'b1; a = 16'd99; b = 16'd77; end
      if (c == 15) start = 1'b0;
      if (c == 10) check("busy_mid_run", 32'(busy), 32'd1);
      @(negedge clk);
      if (done) dones++;
    end
    check("single_done", dones, 1);
    check("product_ignore_restart", product, 32'd15);

    // Reset mid-operation aborts with no done afterwards.
    run_op(16'd37, 16'd870, 32'h00007DBE);
    @(negedge clk);
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_leds", 32'(leds), 32'h1);
    check("abort_out", 32'(out), 32'b1000000);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no_done_after_abort", dones, 0);
    run_op(16'd100, 16'd200, 32'd20000);

    // Continuous start: one result every WIDTH+2 cycles.
    @(negedge clk);
    a = 16'd2; b = 16'd3; start = 1'b1;
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    t0 = n;
    @(negedge clk); n++;
    while (!done && n < 80) begin @(negedge clk); n++; end
    start = 1'b0;
    check("back_to_back_period", n - t0, 18);
    check("back_to_back_product", product, 32'd6);

    run_op(16'd37, 16'd870, 32'h00007DBE);
    show(1'b0, {7'b1111000, 7'b0100001, 7'b0000011, 7'b0000110});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
